// File: rtl/systolic_ws_pkg.sv
// Shared types for the weight-stationary systolic array front end.
package systolic_ws_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_e;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/systolic_ws_wbank.sv
// LENGTH x COL_NUM weight register bank with single-row write and whole-matrix load.
module systolic_ws_wbank
    import systolic_ws_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int COL_NUM    = 8,
    parameter int LENGTH     = 8,
    parameter int ROW_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ROW_W-1:0]      wr_row,
    input  logic [DATA_WIDTH-1:0] wr_data   [0:COL_NUM-1],
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data [0:LENGTH-1][0:COL_NUM-1],
    output logic [DATA_WIDTH-1:0] data_out  [0:LENGTH-1][0:COL_NUM-1]
);

    // NOTE: the bank is reset because the array may read weights before the first launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < LENGTH; r++) begin
                for (int c = 0; c < COL_NUM; c++) begin
                    data_out[r][c] <= '0;
                end
            end
        end else if (load_en) begin
            data_out <= load_data;
        end else if (wr_en) begin
            data_out[wr_row] <= wr_data;
        end
    end

endmodule

// File: rtl/systolic_ws_weight_loader.sv
// Double-buffered weight loader: streams rows into a shadow bank, launches into the active bank.
module systolic_ws_weight_loader
    import systolic_ws_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int COL_NUM    = 8,
    parameter int LENGTH     = 8,
    localparam int LENGTH_ADDR_WIDTH = $clog2(LENGTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         w_val,
    output logic                         w_rdy,
    input  logic [DATA_WIDTH-1:0]        w_row   [0:COL_NUM-1],
    output logic [DATA_WIDTH-1:0]        weights [0:LENGTH-1][0:COL_NUM-1],
    output logic                         val_out,
    input  logic                         rdy_out,
    output logic                         active_valid,
    output logic [LENGTH_ADDR_WIDTH:0]   fill_count
);

    localparam int ROW_W = (LENGTH > 1) ? LENGTH_ADDR_WIDTH : 1;

    typedef logic [DATA_WIDTH-1:0]     weight_t;
    typedef logic [LENGTH_ADDR_WIDTH:0] count_t;

    loader_state_e state;
    logic          row_fire;
    logic          launch;
    weight_t       shadow [0:LENGTH-1][0:COL_NUM-1];
    weight_t       zero_bank [0:LENGTH-1][0:COL_NUM-1];

    // Handshake outputs decode registered state only; reset just masks acceptance.
    assign w_rdy    = (state == FILL) && !reset;
    assign val_out  = (state == FULL);
    assign row_fire = w_val && w_rdy;
    assign launch   = val_out && rdy_out && !reset;

    assign zero_bank = '{default: '0};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FILL;
            fill_count   <= '0;
            active_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (row_fire) begin
                        fill_count <= fill_count + count_t'(1);
                        if (fill_count == count_t'(LENGTH - 1)) begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (rdy_out) begin
                        state        <= FILL;
                        fill_count   <= '0;
                        active_valid <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    systolic_ws_wbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .COL_NUM    (COL_NUM),
        .LENGTH     (LENGTH),
        .ROW_W      (ROW_W)
    ) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (row_fire),
        .wr_row    (fill_count[ROW_W-1:0]),
        .wr_data   (w_row),
        .load_en   (1'b0),
        .load_data (zero_bank),
        .data_out  (shadow)
    );

    // The active bank only ever changes on the launch edge.
    systolic_ws_wbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .COL_NUM    (COL_NUM),
        .LENGTH     (LENGTH),
        .ROW_W      (ROW_W)
    ) u_active (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (1'b0),
        .wr_row    ('0),
        .wr_data   (w_row),
        .load_en   (launch),
        .load_data (shadow),
        .data_out  (weights)
    );

endmodule

// File: tb/tb_systolic_ws_weight_loader.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_systolic_ws_weight_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       w_val = 1'b0;
    logic       w_rdy;
    logic [7:0] w_row   [0:1];
    logic [7:0] weights [0:1][0:1];
    logic       val_out;
    logic       rdy_out = 1'b0;
    logic       active_valid;
    logic [1:0] fill_count;

    logic       reset1 = 1'b1;
    logic       w_val1 = 1'b0;
    logic       w_rdy1;
    logic [7:0] w_row1   [0:2];
    logic [7:0] weights1 [0:0][0:2];
    logic       val_out1;
    logic       rdy_out1 = 1'b0;
    logic       active_valid1;
    logic [0:0] fill_count1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    systolic_ws_weight_loader #(.DATA_WIDTH(8), .COL_NUM(2), .LENGTH(2)) dut (
        .clk(clk), .reset(reset), .w_val(w_val), .w_rdy(w_rdy), .w_row(w_row),
        .weights(weights), .val_out(val_out), .rdy_out(rdy_out),
        .active_valid(active_valid), .fill_count(fill_count)
    );

    systolic_ws_weight_loader #(.DATA_WIDTH(8), .COL_NUM(3), .LENGTH(1)) dut1 (
        .clk(clk), .reset(reset1), .w_val(w_val1), .w_rdy(w_rdy1), .w_row(w_row1),
        .weights(weights1), .val_out(val_out1), .rdy_out(rdy_out1),
        .active_valid(active_valid1), .fill_count(fill_count1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] flat_w();
        logic [31:0] f = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                f = {f[23:0], weights[r][c]};
        return f;
    endfunction

    // Reference model: shadow set is a queue of packed rows, active set a packed matrix.
    logic [15:0] m_q[$];
    logic [31:0] m_active = '0;
    bit          m_av     = 1'b0;
    bit          m_full   = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_active = '0;
            m_av     = 1'b0;
            m_full   = 1'b0;
        end else if (m_full) begin
            if (rdy_out) begin
                m_active = {m_q[0], m_q[1]};
                m_av     = 1'b1;
                m_q.delete();
                m_full   = 1'b0;
            end
        end else if (w_val) begin
            m_q.push_back({w_row[0], w_row[1]});
            if (m_q.size() == 2) m_full = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("w_rdy",        32'(w_rdy),        32'(!m_full && !reset));
            check("val_out",      32'(val_out),      32'(m_full));
            check("fill_count",   32'(fill_count),   32'(m_q.size()));
            check("active_valid", 32'(active_valid), 32'(m_av));
            check("weights",      flat_w(),          m_active);
        end
    end

    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
        w_val    = v;
        w_row[0] = a;
        w_row[1] = b;
        rdy_out  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        w_row[0] = '0; w_row[1] = '0;
        for (int c = 0; c < 3; c++) w_row1[c] = '0;

        step(1, 8'h11, 8'h22, 1);
        step(1, 8'h11, 8'h22, 1);
        chk_en = 1'b1;
        check("rst_w_rdy",   32'(w_rdy),      32'd0);
        check("rst_fill",    32'(fill_count), 32'd0);
        check("rst_weights", flat_w(),        32'h0);
        reset = 1'b0;

        // Basic load
        step(1, 8'd1, 8'd2, 0);
        step(1, 8'd3, 8'd4, 0);
        check("basic_val_out", 32'(val_out), 32'd1);
        step(0, 8'd0, 8'd0, 1);
        check("basic_weights", flat_w(),          32'h01020304);
        check("basic_av",      32'(active_valid), 32'd1);
        check("basic_w_rdy",   32'(w_rdy),        32'd1);

        // Backpressure with ignored w_val pulses
        step(1, 8'd5, 8'd6, 0);
        step(1, 8'd7, 8'd8, 0);
        repeat (10) step(1'($urandom), 8'($urandom), 8'($urandom), 0);
        check("bp_val_out", 32'(val_out), 32'd1);
        check("bp_weights", flat_w(),     32'h01020304);
        step(0, 8'd0, 8'd0, 1);
        check("bp_launch",  flat_w(),     32'h05060708);

        // Overlap: new set streams while the previous one is in use
        step(1, 8'd9, 8'd10, 0);
        step(1, 8'd11, 8'd12, 0);
        check("ovl_hold",   flat_w(), 32'h05060708);
        step(0, 8'd0, 8'd0, 1);
        check("ovl_launch", flat_w(), 32'h090a0b0c);

        // Bubbles
        step(1, 8'd13, 8'd14, 0);
        check("bub_fill1", 32'(fill_count), 32'd1);
        step(0, 8'd0, 8'd0, 0);
        check("bub_fill2", 32'(fill_count), 32'd1);
        step(0, 8'd0, 8'd0, 0);
        check("bub_fill3", 32'(fill_count), 32'd1);
        check("bub_noval", 32'(val_out),    32'd0);
        step(1, 8'd15, 8'd16, 0);
        check("bub_fill4", 32'(fill_count), 32'd2);
        check("bub_val",   32'(val_out),    32'd1);
        step(0, 8'd0, 8'd0, 1);

        // Reset mid-fill, then a fresh set
        step(1, 8'd1, 8'd2, 0);
        reset = 1'b1;
        step(0, 8'd0, 8'd0, 0);
        check("mrst_fill",    32'(fill_count),   32'd0);
        check("mrst_weights", flat_w(),          32'h0);
        check("mrst_av",      32'(active_valid), 32'd0);
        reset = 1'b0;
        step(1, 8'h21, 8'h22, 1);
        step(1, 8'h23, 8'h24, 1);
        step(0, 8'd0, 8'd0, 1);
        check("mrst_reload", flat_w(), 32'h21222324);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            step(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        reset = 1'b0;

        // LENGTH=1, COL_NUM=3 instance
        reset1 = 1'b0;
        w_val1 = 1'b1;
        w_row1[0] = 8'd7; w_row1[1] = 8'd8; w_row1[2] = 8'd9;
        @(posedge clk); #1;
        w_val1 = 1'b0;
        check("l1_val_out", 32'(val_out1),    32'd1);
        check("l1_w_rdy",   32'(w_rdy1),      32'd0);
        check("l1_fill",    32'(fill_count1), 32'd1);
        check("l1_hold",    {8'h0, weights1[0][0], weights1[0][1], weights1[0][2]}, 32'h0);
        rdy_out1 = 1'b1;
        @(posedge clk); #1;
        rdy_out1 = 1'b0;
        check("l1_weights", {8'h0, weights1[0][0], weights1[0][1], weights1[0][2]}, 32'h070809);
        check("l1_av",      32'(active_valid1), 32'd1);
        check("l1_fill0",   32'(fill_count1),   32'd0);
        check("l1_rdy",     32'(w_rdy1),        32'd1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
